// File: rtl/serial_bit_source.sv
// Parallel-to-serial word source driving the "101" detector's x input, MSB first.
// Optional SER_PRELOAD_EN adds a one-entry holding buffer for gapless word streaming.
module serial_bit_source #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] data_in,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             hold,
    output logic             x_out,
    output logic             x_valid,
    output logic             x_last
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state;
    state_t           state_d;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] sreg_d;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_d;
    logic             accept;
    logic             word_end;

`ifdef SER_PRELOAD_EN
    logic [WIDTH-1:0] pbuf;
    logic [WIDTH-1:0] pbuf_d;
    logic             buf_full;
    logic             buf_full_d;

    assign in_ready = !buf_full;
`else
    assign in_ready = (state == IDLE);
`endif

    assign accept   = in_valid && in_ready;
    assign word_end = (state == SHIFT) && !hold && (cnt == '0);

    // Outputs decode registered state only; x_out is forced low between words.
    assign x_valid = (state == SHIFT);
    assign x_out   = x_valid && sreg[WIDTH-1];
    assign x_last  = x_valid && (cnt == '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            sreg     <= '0;
            cnt      <= '0;
`ifdef SER_PRELOAD_EN
            pbuf     <= '0;
            buf_full <= 1'b0;
`endif
        end else begin
            state    <= state_d;
            sreg     <= sreg_d;
            cnt      <= cnt_d;
`ifdef SER_PRELOAD_EN
            pbuf     <= pbuf_d;
            buf_full <= buf_full_d;
`endif
        end
    end

    always_comb begin
        state_d = state;
        sreg_d  = sreg;
        cnt_d   = cnt;
`ifdef SER_PRELOAD_EN
        pbuf_d     = pbuf;
        buf_full_d = buf_full;
`endif
        case (state)
            IDLE: begin
                if (accept) begin
                    sreg_d  = data_in;
                    cnt_d   = CNT_MAX;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (!hold) begin
                    sreg_d = sreg << 1;
                    cnt_d  = cnt - 1'b1;
                end
                if (word_end) begin
`ifdef SER_PRELOAD_EN
                    // Buffered word wins; otherwise a same-edge accept bypasses the buffer.
                    if (buf_full) begin
                        sreg_d     = pbuf;
                        cnt_d      = CNT_MAX;
                        buf_full_d = 1'b0;
                    end else if (accept) begin
                        sreg_d = data_in;
                        cnt_d  = CNT_MAX;
                    end else begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
`else
                    state_d = IDLE;
                    cnt_d   = '0;
`endif
                end
`ifdef SER_PRELOAD_EN
                if (!word_end && accept) begin
                    pbuf_d     = data_in;
                    buf_full_d = 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_serial_bit_source.sv
// Self-checking bench for serial_bit_source: directed scenarios plus random traffic
// compared cycle by cycle against a bit-queue reference model.
module tb_serial_bit_source;

    localparam int unsigned WIDTH = 8;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic [WIDTH-1:0] data_in = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic             hold = 1'b0;
    logic             x_out;
    logic             x_valid;
    logic             x_last;

    int checks = 0;
    int errors = 0;

    // Reference model: bits of the current word still to be shown, plus an optional pending word.
    bit               cur_q[$];
    logic [WIDTH-1:0] pend;
    bit               pend_v = 1'b0;

    // Observation record of the DUT's serial stream.
    bit obs_bits[$];
    bit valid_hist[$];

    serial_bit_source #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .data_in  (data_in),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .hold     (hold),
        .x_out    (x_out),
        .x_valid  (x_valid),
        .x_last   (x_last)
    );

    always #5 clk = ~clk;

    function automatic bit m_ready();
`ifdef SER_PRELOAD_EN
        return !pend_v;
`else
        return cur_q.size() == 0;
`endif
    endfunction

    task automatic m_load(input logic [WIDTH-1:0] w);
        cur_q.delete();
        for (int i = WIDTH - 1; i >= 0; i--) cur_q.push_back(w[i]);
    endtask

    task automatic m_reset();
        cur_q.delete();
        pend_v = 1'b0;
    endtask

    task automatic m_edge(input logic v, input logic [WIDTH-1:0] d, input logic h, output bit acc);
        bit fin;
        acc = v && m_ready();
        if (cur_q.size() == 0) begin
            if (acc) m_load(d);
        end else begin
            fin = !h && (cur_q.size() == 1);
            if (!h) void'(cur_q.pop_front());
            if (fin) begin
                if (pend_v) begin
                    m_load(pend);
                    pend_v = 1'b0;
                end else if (acc) begin
                    m_load(d);
                end
            end else if (acc) begin
                pend   = d;
                pend_v = 1'b1;
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        bit ev;
        ev = cur_q.size() != 0;
        check("x_valid", 32'(x_valid), 32'(ev));
        check("x_out", 32'(x_out), ev ? 32'(cur_q[0]) : 32'd0);
        check("x_last", 32'(x_last), 32'(cur_q.size() == 1));
        check("in_ready", 32'(in_ready), 32'(m_ready()));
        valid_hist.push_back(x_valid === 1'b1);
        if (x_valid === 1'b1) obs_bits.push_back(x_out === 1'b1);
    endtask

    // Drive inputs (called at a falling edge), let one rising edge pass, check at next falling edge.
    task automatic step(input logic v, input logic [WIDTH-1:0] d, input logic h, output bit acc);
        in_valid = v;
        data_in  = d;
        hold     = h;
        @(posedge clk);
        m_edge(v, d, h, acc);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle_steps(input int n);
        bit a;
        for (int i = 0; i < n; i++) step(1'b0, WIDTH'($urandom), 1'b0, a);
    endtask

    task automatic send_held(input logic [WIDTH-1:0] w, input string tag);
        bit a = 1'b0;
        for (int k = 0; k < 40 && !a; k++) step(1'b1, w, 1'b0, a);
        check(tag, 32'(a), 32'd1);
    endtask

    function automatic logic [31:0] obs_pack();
        logic [31:0] r = '0;
        foreach (obs_bits[i]) r = {r[30:0], obs_bits[i]};
        return r;
    endfunction

    function automatic int count_valid();
        int n = 0;
        foreach (valid_hist[i]) if (valid_hist[i]) n++;
        return n;
    endfunction

    function automatic int inner_gap();
        int first = -1;
        int last  = -1;
        int g     = 0;
        foreach (valid_hist[i]) if (valid_hist[i]) begin
            if (first < 0) first = i;
            last = i;
        end
        for (int i = first; i <= last && first >= 0; i++) if (!valid_hist[i]) g++;
        return g;
    endfunction

    task automatic clear_obs();
        obs_bits.delete();
        valid_hist.delete();
    endtask

    initial begin
        bit a;
        int exp_gap;

        // Reset held from time zero: outputs quiet and ready.
        @(negedge clk);
        check_outputs();
        reset_n = 1'b1;
        idle_steps(2);

        // Single word 8'hA5.
        clear_obs();
        step(1'b1, 8'hA5, 1'b0, a);
        idle_steps(10);
        check("a5_stream", obs_pack(), 32'h0000_00A5);
        check("a5_len", 32'(obs_bits.size()), 32'd8);

        // Stall: hold three cycles after the third bit is shown.
        clear_obs();
        step(1'b1, 8'hA5, 1'b0, a);
        idle_steps(3);
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, a);
        idle_steps(10);
        check("stall_span", 32'(count_valid()), 32'd11);

        // Two words with in_valid held throughout.
        clear_obs();
        send_held(8'h0F, "accept_0f");
        send_held(8'hF0, "accept_f0");
        idle_steps(20);
`ifdef SER_PRELOAD_EN
        exp_gap = 0;
`else
        exp_gap = 1;
`endif
        check("pair_stream", obs_pack(), 32'h0000_0FF0);
        check("pair_gap", 32'(inner_gap()), 32'(exp_gap));

        // Reset in the middle of a word, then a fresh word.
        step(1'b1, 8'hFF, 1'b0, a);
        idle_steps(4);
        #2 reset_n = 1'b0;
        #1;
        m_reset();
        check("rst_x_valid", 32'(x_valid), 32'd0);
        check("rst_x_out", 32'(x_out), 32'd0);
        check("rst_x_last", 32'(x_last), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        check_outputs();
        reset_n = 1'b1;
        clear_obs();
        step(1'b1, 8'h80, 1'b0, a);
        idle_steps(10);
        check("post_rst_stream", obs_pack(), 32'h0000_0080);
        check("post_rst_len", 32'(obs_bits.size()), 32'd8);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++)
            step(1'($urandom_range(0, 1)), WIDTH'($urandom), 1'($urandom_range(0, 3) == 0), a);
        idle_steps(12);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_bit_source.md
# serial_bit_source

Parallel-to-serial source feeding the Moore "101" sequence detector. Accepts a WIDTH-bit word over a valid/ready handshake. Emits the word MSB-first, one bit per clock, on a single serial line that connects directly to the detector's `x` input. Provides stall control and word framing so benches and upstream logic can drive the detector with arbitrary bit streams.

## Interface
- `WIDTH`, 8: bits per word; legal range 2..32.
- `clk`  input  1  rising-edge clock.
- `reset_n`  input  1  reset; **asynchronous, active-low**. The block has one clock; reset polarity and synchronicity are fixed.
- `data_in`  input  WIDTH  word to serialize; sampled on accept.
- `in_valid`  input  1  `data_in` is valid.
- `in_ready`  output  1  block can accept a word this cycle.
- `hold`  input  1  stall; freezes the shift when 1.
- `x_out`  output  1  serial bit to the detector's `x`.
- `x_valid`  output  1  `x_out` carries a word bit.
- `x_last`  output  1  `x_out` is bit 0 (the final bit) of the current word.

## Operation
- **Accept.** An accept occurs at a rising edge when `in_valid && in_ready`.
- **Datapath.** WIDTH-bit shift register `sreg`, plus a down-counter `cnt` of width $clog2(WIDTH).
- **States.** IDLE and SHIFT.
  - IDLE: `x_out=0`, `x_valid=0`, `x_last=0`.
  - IDLE + accept: `sreg<=data_in`, `cnt<=WIDTH-1`, go to SHIFT.
  - SHIFT: `x_out=sreg[WIDTH-1]`, `x_valid=1`, `x_last=(cnt==0)`.
  - Advance in SHIFT (`hold=0`): `sreg<=sreg<<1`, `cnt<=cnt-1`.
  - Advance with `cnt==0` is the end-of-word edge. The next word is loaded if one is available (see Configuration); otherwise go to IDLE.
- **Hold.** `hold=1` in SHIFT freezes `sreg` and `cnt`. `x_out`, `x_valid` and `x_last` stay stable. `hold` has no effect in IDLE. `hold` does not block accepts.
- **Idle output.** `x_out` is driven 0 whenever `x_valid=0`, so the detector sees zeros between words.
- **Ignored data.** `data_in` is ignored when no accept occurs. `in_valid` dropping without an accept is legal.
- **Reset.** `reset_n` low immediately forces:
  - state IDLE, `sreg=0`, `cnt=0`, holding buffer empty;
  - `x_out=0`, `x_valid=0`, `x_last=0`;
  - `in_ready=1`, including while reset is held.
- **Reset mid-word.** Asserting reset during a word abandons the remaining bits. The next accepted word starts from its MSB.

## Timing
- **Latency.** Word accepted at edge N: its MSB is on `x_out` from after edge N until edge N+1. Bit k (MSB=1) is present in cycle N+k, absent stalls.
- **Word length.** A word occupies exactly WIDTH cycles plus the number of `hold=1` cycles spent in SHIFT.
- **Outputs.** All outputs are registered-state decodes with no combinational path from `in_valid` or `data_in`. `in_ready` depends only on state and the buffer flag.
- **Without SER_PRELOAD_EN:** `in_ready=(state==IDLE)`. At least one IDLE cycle separates consecutive words, so throughput is one word per WIDTH+1 cycles.
- **With SER_PRELOAD_EN:** see Configuration; back-to-back words stream with zero gap.

## Configuration
- Macro: `SER_PRELOAD_EN`.
- **Defined.** Adds a one-entry holding buffer (`buf`, `buf_full`).
  - `in_ready = !buf_full`.
  - Accept in IDLE loads `sreg` directly.
  - Accept in SHIFT on a non-end edge writes the word to `buf` and sets `buf_full`.
  - On an end-of-word edge the next word is loaded as follows:
    - if `buf_full`: load `buf` into `sreg`, clear `buf_full`, stay in SHIFT;
    - else if an accept occurs on the same edge: bypass, load `data_in` into `sreg`, stay in SHIFT;
    - else go to IDLE.
  - In both load cases `cnt<=WIDTH-1`.
  - An accept while `buf_full=1` is impossible because `in_ready=0`.
  - With `hold=1`, the end-of-word edge does not occur; an accept writes `buf` as usual.
- **Undefined.** No buffer logic is present and behaviour is exactly as described in Operation.

## Test plan
- **Reset.** Assert `reset_n=0` asynchronously mid-cycle → `x_out=0`, `x_valid=0`, `x_last=0`, `in_ready=1` before the next edge.
- **Single word, WIDTH=8.** Accept 8'hA5 → `x_out`=1,0,1,0,0,1,0,1 on cycles N+1..N+8, `x_last=1` only on N+8. The detector's `y` pulses for each "101" in the stream. Without the macro, `in_ready=0` on N+1..N+8.
- **Stall.** Accept 8'hA5 and raise `hold` for 3 cycles after the 3rd bit → the 4th bit (0) is held for 4 cycles, the word spans 11 cycles, and the bit order is unchanged.
- **No preload.** With `in_valid` held and 8'h0F then 8'hF0 presented → exactly one cycle with `x_valid=0`, `x_out=0`, `in_ready=1` between the two words.
- **Preload defined.** Present 8'h05 then 8'hA0 back-to-back, plus a bypass case (accept on the end-of-word edge with the buffer empty) → `x_valid=1` for 16 contiguous cycles carrying stream 00000101_10100000, and `in_ready` deasserts while the buffer is full.
- **Reset mid-word.** Accept 8'hFF, assert reset after 4 bits, release, then accept 8'h80 → 1 followed by seven 0s, with no leftover 1s from 8'hFF.
